// File: rtl/unsigned_multiply_accumulate_16_bit_pkg.sv
// Shared definitions for the 16-bit unsigned multiply-accumulate block.
package unsigned_multiply_accumulate_16_bit_pkg;

    localparam int OPERAND_W    = 16;
    localparam int PRODUCT_W    = 32;
    localparam int DRAIN_CYCLES = 2;

    // state      | meaning
    // ST_ACCUM   | taking operand pairs, counting samples of the frame
    // ST_DRAIN   | last pair taken; product and accumulate stages flushing
    // ST_OUTPUT  | frame sum presented, waiting for the consumer handshake
    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_OUTPUT = 2'd2
    } mac_state_e;

endpackage

// File: rtl/unsigned_multiply_accumulate_16_bit_mult.sv
// Combinational 16x16 unsigned array multiplier (shift-and-add partial products).
module unsigned_array_multiplier_16_bit
    import unsigned_multiply_accumulate_16_bit_pkg::*;
(
    input  logic                 Enable_In,
    input  logic [OPERAND_W-1:0] Data_A_In,
    input  logic [OPERAND_W-1:0] Data_B_In,
    output logic [PRODUCT_W-1:0] Product_Out
);

    logic [PRODUCT_W-1:0] pp_sum;

    // Sum one shifted copy of A per set bit of B; output forced to zero when disabled.
    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < OPERAND_W; i++) begin
            if (Data_B_In[i]) begin
                pp_sum = pp_sum + (PRODUCT_W'(Data_A_In) << i);
            end
        end
        Product_Out = Enable_In ? pp_sum : '0;
    end

endmodule

// File: rtl/unsigned_multiply_accumulate_16_bit.sv
// Framed unsigned MAC: operand register -> product register -> accumulator,
// sequenced by an ACCUM/DRAIN/OUTPUT controller with valid/ready handshakes.
module unsigned_multiply_accumulate_16_bit
    import unsigned_multiply_accumulate_16_bit_pkg::*;
#(
    parameter int ACC_LENGTH = 16,
    parameter int ACC_WIDTH  = 36
) (
    input  logic                 Clk_In,
    input  logic                 Reset_n_In,
    input  logic                 Clear_In,
    input  logic                 Data_Valid_In,
    output logic                 Data_Ready_Out,
    input  logic [OPERAND_W-1:0] Data_A_In,
    input  logic [OPERAND_W-1:0] Data_B_In,
    output logic                 Result_Valid_Out,
    input  logic                 Result_Ready_In,
    output logic [ACC_WIDTH-1:0] Result_Out,
    output logic                 Overflow_Out
);

    localparam int CNT_W = $clog2(ACC_LENGTH);
    localparam int SUM_W = ACC_WIDTH + 1;

    mac_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           drain_q, drain_d;
    logic [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
    logic                 v1_q, v1_d;
    logic [PRODUCT_W-1:0] prod_q, prod_d;
    logic                 v2_q, v2_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic [PRODUCT_W-1:0] prod_w;
    logic [SUM_W-1:0]     sum_w;
    logic                 accept_w;

    unsigned_array_multiplier_16_bit u_mult (
        .Enable_In   (1'b1),
        .Data_A_In   (a_q),
        .Data_B_In   (b_q),
        .Product_Out (prod_w)
    );

    // Next-state for controller and all three pipeline stages; Clear_In applied last so it wins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        a_d      = a_q;
        b_d      = b_q;
        v1_d     = 1'b0;
        prod_d   = prod_q;
        v2_d     = v1_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        sum_w    = {1'b0, acc_q} + SUM_W'(prod_q);
        accept_w = (state_q == ST_ACCUM) && Data_Valid_In;

        if (accept_w) begin
            a_d  = Data_A_In;
            b_d  = Data_B_In;
            v1_d = 1'b1;
            if (cnt_q == CNT_W'(ACC_LENGTH - 1)) begin
                cnt_d   = '0;
                drain_d = '0;
                state_d = ST_DRAIN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (v1_q) begin
            prod_d = prod_w;
        end

        if (v2_q) begin
            acc_d = sum_w[ACC_WIDTH-1:0];
            ovf_d = ovf_q | sum_w[ACC_WIDTH];
        end

        case (state_q)
            ST_DRAIN: begin
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_OUTPUT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (Result_Ready_In) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: ;
        endcase

        if (Clear_In) begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
            drain_d = '0;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // State register with synchronous active-low reset discarding everything in flight.
    always_ff @(posedge Clk_In) begin
        if (!Reset_n_In) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            v1_q    <= 1'b0;
            prod_q  <= '0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v1_q    <= v1_d;
            prod_q  <= prod_d;
            v2_q    <= v2_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs are held low while reset is asserted.
    assign Data_Ready_Out   = Reset_n_In && (state_q == ST_ACCUM);
    assign Result_Valid_Out = Reset_n_In && (state_q == ST_OUTPUT);
    assign Result_Out       = acc_q;
    assign Overflow_Out     = ovf_q;

endmodule
